// File: rtl/alu_result_writer.sv
// ALU result write-back into a single-port SRAM, with random-access readback.
// Optional ALU_RESULT_WRITER_WRAP_EN: keep writing past full, overwriting oldest.
module alu_result_writer #(
  parameter int width_p      = 8,
  parameter int els_p        = 512,
  parameter int addr_width_p = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    res_v_i,
  input  logic [width_p-1:0]      res_i,
  output logic                    res_ready_o,
  input  logic                    rd_v_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    rd_ready_o,
  output logic                    rd_v_o,
  output logic [width_p-1:0]      rd_data_o,
  output logic [addr_width_p:0]   count_o,
  output logic                    full_o,
  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [addr_width_p-1:0] sram_addr_o,
  output logic [width_p-1:0]      sram_wd_o,
  output logic [width_p-1:0]      sram_w_mask_o,
  input  logic [width_p-1:0]      sram_rd_i
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } state_t;

  localparam logic [addr_width_p:0] full_c =
    (addr_width_p+1)'(els_p);

  state_t state_r, state_n;

  logic [width_p-1:0]      data_r;
  logic [addr_width_p-1:0] raddr_r;
  logic [addr_width_p-1:0] wr_ptr_r;
  logic [addr_width_p:0]   count_r;
  logic [width_p-1:0]      rd_data_r;
  logic                    rd_v_r;

  logic full, wr_ok, idle;
  logic res_rdy, rd_rdy;
  logic wr_hs, rd_hs;

  assign full = (count_r == full_c);

`ifdef ALU_RESULT_WRITER_WRAP_EN
  assign wr_ok = 1'b1;
`else
  assign wr_ok = ~full;
`endif

  // Readies are forced low while reset is held.
  assign idle    = (state_r == IDLE);
  assign res_rdy = reset_n_i & idle & wr_ok;
  assign rd_rdy  = reset_n_i & idle & ~res_v_i;
  assign wr_hs   = res_v_i & res_rdy;
  assign rd_hs   = rd_v_i & rd_rdy;

  assign res_ready_o   = res_rdy;
  assign rd_ready_o    = rd_rdy;
  assign rd_v_o        = rd_v_r;
  assign rd_data_o     = rd_data_r;
  assign count_o       = count_r;
  assign full_o        = full;
  assign sram_w_mask_o = '1;

  always_comb begin
    state_n     = state_r;
    sram_ce_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = '0;
    sram_wd_o   = '0;
    unique case (state_r)
      IDLE: begin
        if (wr_hs)
          state_n = WR;
        else if (rd_hs)
          state_n = RD;
      end
      WR: begin
        sram_ce_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = wr_ptr_r;
        sram_wd_o   = data_r;
        state_n     = IDLE;
      end
      RD: begin
        sram_ce_o   = 1'b1;
        sram_addr_o = raddr_r;
        state_n     = RD_WAIT;
      end
      RD_WAIT: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      data_r    <= '0;
      raddr_r   <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      rd_data_r <= '0;
      rd_v_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      rd_v_r  <= (state_r == RD_WAIT);
      if (wr_hs)
        data_r <= res_i;
      if (rd_hs)
        raddr_r <= rd_addr_i;
      if (state_r == WR) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
        if (!full)
          count_r <= count_r + 1'b1;
      end
      if (state_r == RD_WAIT)
        rd_data_r <= sram_rd_i;
    end
  end

endmodule

// File: tb/tb_alu_result_writer.sv
// Bench for alu_result_writer: SRAM model, cycle model of the
// handshake timing, and directed scenarios with literal expectations.
module tb_alu_result_writer;

`ifdef ALU_RESULT_WRITER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       res_v = 1'b0;
  logic [7:0] res_d = '0;
  logic       res_ready_o;
  logic       rd_v = 1'b0;
  logic [8:0] rd_a = '0;
  logic       rd_ready_o;
  logic       rd_v_o;
  logic [7:0] rd_data_o;
  logic [9:0] count_o;
  logic       full_o;
  logic       sram_ce_o;
  logic       sram_we_o;
  logic [8:0] sram_addr_o;
  logic [7:0] sram_wd_o;
  logic [7:0] sram_w_mask_o;
  logic [7:0] sram_rd = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_writer dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .res_v_i       (res_v),
    .res_i         (res_d),
    .res_ready_o   (res_ready_o),
    .rd_v_i        (rd_v),
    .rd_addr_i     (rd_a),
    .rd_ready_o    (rd_ready_o),
    .rd_v_o        (rd_v_o),
    .rd_data_o     (rd_data_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .sram_ce_o     (sram_ce_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wd_o     (sram_wd_o),
    .sram_w_mask_o (sram_w_mask_o),
    .sram_rd_i     (sram_rd)
  );

  // Synchronous single-port SRAM: read data appears after the sampling edge.
  logic [7:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o)
        mem[sram_addr_o] <= sram_wd_o;
      else
        sram_rd <= mem[sram_addr_o];
    end
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: contents, pointer, count and future events in a small ring.
  logic [7:0] m_mem [512];
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [7:0] m_rd = '0;
  int         mcyc = 0;
  int         busy_to = -1;
  bit         s_ce [8];
  bit         s_we [8];
  logic [8:0] s_addr [8];
  logic [7:0] s_wd [8];
  bit         s_inc [8];
  bit         s_rdv [8];
  logic [7:0] s_rdd [8];

  initial for (int i = 0; i < 512; i++) m_mem[i] = '0;

  task automatic clr_slot(input int s);
    s_ce[s] = 0; s_we[s] = 0; s_addr[s] = '0; s_wd[s] = '0;
    s_inc[s] = 0; s_rdv[s] = 0; s_rdd[s] = '0;
  endtask

  always @(negedge clk) begin
    int s, s1;
    bit er, ed;
    s  = mcyc & 7;
    s1 = (mcyc + 1) & 7;
    if (!reset_n) begin
      chk("rst_sram", {sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o}, 0);
      chk("rst_mask", sram_w_mask_o, 8'hFF);
      chk("rst_rd", {rd_v_o, rd_data_o}, 0);
      chk("rst_cnt", {full_o, count_o}, 0);
      chk("rst_rdy", {res_ready_o, rd_ready_o}, 0);
      for (int i = 0; i < 8; i++) clr_slot(i);
      m_cnt = 0; m_ptr = 0; m_rd = '0; busy_to = mcyc;
    end else begin
      if (s_inc[s]) m_cnt = (m_cnt == 512) ? 512 : m_cnt + 1;
      if (s_rdv[s]) m_rd = s_rdd[s];
      chk("sram_bus", {sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o},
          {s_ce[s], s_we[s], s_addr[s], s_wd[s]});
      chk("sram_mask", sram_w_mask_o, 8'hFF);
      chk("rd_v", rd_v_o, s_rdv[s]);
      chk("rd_data", rd_data_o, m_rd);
      chk("count", count_o, m_cnt);
      chk("full", full_o, m_cnt == 512);
      er = (mcyc > busy_to) && (WRAP || m_cnt != 512);
      ed = (mcyc > busy_to) && !res_v;
      chk("res_ready", res_ready_o, er);
      chk("rd_ready", rd_ready_o, ed);
      clr_slot(s);
      if (res_v && er) begin
        s_ce[s1] = 1; s_we[s1] = 1;
        s_addr[s1] = 9'(m_ptr); s_wd[s1] = res_d;
        m_mem[m_ptr] = res_d;
        s_inc[(mcyc + 2) & 7] = 1;
        m_ptr = (m_ptr + 1) % 512;
        busy_to = mcyc + 1;
      end else if (rd_v && ed) begin
        s_ce[s1] = 1; s_addr[s1] = rd_a;
        s_rdv[(mcyc + 3) & 7] = 1;
        s_rdd[(mcyc + 3) & 7] = m_mem[rd_a];
        busy_to = mcyc + 2;
      end
    end
    mcyc++;
  end

  task automatic do_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // Leaves res_v high so consecutive calls run back-to-back.
  task automatic do_write(input logic [7:0] d);
    bit hs = 0;
    int n = 0;
    res_v = 1; res_d = d;
    while (!hs && n < 20) begin
      @(negedge clk);
      if (res_ready_o) hs = 1; else n++;
      @(posedge clk); #1;
    end
    chk("wr_hs", hs, 1);
  endtask

  task automatic do_read(input logic [8:0] a, output logic [7:0] d,
                         output int waits, output int lat);
    bit hs = 0;
    waits = 0; lat = 0;
    rd_v = 1; rd_a = a;
    while (!hs && waits < 20) begin
      @(negedge clk);
      if (rd_ready_o) hs = 1; else waits++;
      @(posedge clk); #1;
    end
    rd_v = 0;
    chk("rd_hs", hs, 1);
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_v_o && lat < 10);
    d = rd_data_o;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp4 [4];
    int w, l;
    bit seen;
    exp4 = '{8'd1, 8'd3, 8'd4, 8'd2};

    do_reset();
    @(negedge clk);
    chk("idle_cnt", count_o, 0);
    chk("idle_rd_data", rd_data_o, 0);
    chk("idle_mask", sram_w_mask_o, 8'hFF);
    chk("idle_rdy", {res_ready_o, rd_ready_o}, 2'b11);
    chk("idle_ce", sram_ce_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) do_write(exp4[i]);
    res_v = 0;
    @(posedge clk); #1;
    chk("cnt4", count_o, 4);
    for (int i = 0; i < 4; i++) begin
      do_read(9'(i), d, w, l);
      chk("rb_data", d, exp4[i]);
      chk("rb_lat", l, 3);
    end
    @(posedge clk); #1;

    res_v = 1; res_d = 8'h09; rd_v = 1; rd_a = 9'd0;
    @(negedge clk);
    chk("both_rd_ready", rd_ready_o, 0);
    chk("both_res_ready", res_ready_o, 1);
    @(posedge clk); #1;
    res_v = 0;
    do_read(9'd0, d, w, l);
    chk("both_rd_waits", w, 1);
    chk("both_rd_data", d, 8'd1);
    @(posedge clk); #1;
    chk("cnt5", count_o, 5);

    rd_v = 1; rd_a = 9'd1;
    @(negedge clk);
    chk("mid_rd_ready", rd_ready_o, 1);
    @(posedge clk); #2;
    rd_v = 0;
    chk("mid_rd_ce", sram_ce_o, 1);
    reset_n = 0;
    #1;
    chk("mid_rst_ce", sram_ce_o, 0);
    chk("mid_rst_rdy", res_ready_o, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_v_o) seen = 1;
    end
    chk("mid_no_rdv", seen, 0);
    @(posedge clk); #1;

    do_reset();
    for (int i = 0; i < 512; i++) do_write(8'(i));
    res_v = 0;
    @(posedge clk); #1;
    chk("fill_cnt", count_o, 512);
    chk("fill_full", full_o, 1);
    if (!WRAP) begin
      chk("fill_res_ready", res_ready_o, 0);
      res_v = 1; res_d = 8'hAA;
      repeat (5) @(negedge clk);
      chk("stall_ready", res_ready_o, 0);
      @(posedge clk); #1;
      res_v = 0;
      chk("stall_cnt", count_o, 512);
      do_read(9'd5, d, w, l);
      chk("full_rb", d, 8'd5);
      do_read(9'd0, d, w, l);
      chk("full_rb0", d, 8'd0);
    end else begin
      do_write(8'hAA);
      res_v = 0;
      @(posedge clk); #1;
      chk("wrap_cnt", count_o, 512);
      chk("wrap_full", full_o, 1);
      do_read(9'd0, d, w, l);
      chk("wrap_rb0", d, 8'hAA);
      do_read(9'd1, d, w, l);
      chk("wrap_rb1", d, 8'd1);
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
